inst_buffer: RTL
================

Name: inst_buffer

Overview:
- Circular instruction queue directly upstream of the decode stage.
- Absorbs up to FETCH_WIDTH fetched instructions per cycle from the fetch/predecode side and presents up to FETCH_WIDTH instructions per cycle, in program order, to the decode units.
- Decouples fetch from backend back-pressure (rename/dispatch full), and is emptied on backend redirect or commit walk.

Parameters:
- FETCH_WIDTH, 4, lanes per cycle on enqueue and dequeue.
- DEPTH, 16, entries. Must be a power of two and >= 2*FETCH_WIDTH.
- INST_W, 32, instruction width.
- FSQ_INFO_W, 8, width of the per-instruction fetch-target-queue info carried alongside each instruction.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_en  in  FETCH_WIDTH  per-lane valid from fetch; contiguous from lane 0
- in_inst  in  FETCH_WIDTH*INST_W  instructions
- in_iam  in  FETCH_WIDTH  instruction-address-misaligned flag per lane
- in_ipf  in  FETCH_WIDTH  instruction page fault flag per lane
- in_fsq_info  in  FETCH_WIDTH*FSQ_INFO_W  fetch-target-queue info per lane
- in_ready  out  1  buffer accepts an in_en group this cycle
- stall  in  1  backend not consuming (rename_full | dis_full)
- flush  in  1  backend redirect | commit walk
- out_en  out  FETCH_WIDTH  per-lane valid to decode
- out_inst, out_iam, out_ipf, out_fsq_info  out  same widths as inputs  head entries, lane i = head+i
- full_cycles  out  32  performance counter of cycles with in_ready=0 while any in_en is set

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk.
  - Values in reset: head=0, tail=0, count=0, full_cycles=0.
  - Resulting outputs: out_en=0, in_ready=1.
  - Entry payload storage is not reset.
- Pointers:
  - head and tail are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH+1) bits and ranges 0..DEPTH.
- in_ready is combinational: ~flush & (DEPTH - count >= FETCH_WIDTH). It depends only on the registered count and never on the current dequeue.
- Enqueue, when in_ready & |in_en:
  - Lane i is written to entry tail+i for each set in_en[i].
  - tail advances by popcount(in_en).
  - Inputs with in_ready=0 are dropped; fetch must hold them.
- Dequeue outputs are combinational from registered state: out_en[i] = (i < count) & ~flush, and payload lane i = entry[(head+i) mod DEPTH].
- Dequeue fire: when ~stall & ~flush, head advances by min(count, FETCH_WIDTH). With stall=1, head and the outputs stay stable.
- Simultaneous enqueue and dequeue: count_next = count + enq_n - deq_n.
- Latency: an instruction enqueued in cycle N is visible on out_en no earlier than cycle N+1. There is no bypass.
- Flush has priority over everything:
  - Next cycle: head=tail=count=0.
  - Same cycle: enqueue suppressed (in_ready=0) and out_en=0.
  - If flush and stall are both set, flush wins.
- Full: count > DEPTH-FETCH_WIDTH deasserts in_ready, even if a dequeue fires in that cycle.
- Empty: count=0 gives out_en=0 and head is unchanged.
- Wrap-around: lanes straddling the DEPTH-1 to 0 boundary are ordered correctly on both enqueue and dequeue.
- full_cycles: increments by 1 (saturating at all ones) each cycle where ~in_ready & |in_en & ~flush.
- Assertions for the bench:
  - in_en is contiguous (in_en[i+1] implies in_en[i]).
  - count never exceeds DEPTH.

Test Plan:
- Reset then in_en=4'b1111, inst A0..A3, stall=0 → next cycle out_en=1111 with lanes A0..A3; following cycle count=0, out_en=0.
- stall=1; enqueue four groups of 4 → after 3 groups (count=12) in_ready=1; after 4 groups (count=16) in_ready=0 and full_cycles increments each cycle in_en is held; outputs hold the first group unchanged.
- Enqueue 3 instructions (in_en=0111) with stall=0 → out_en=0111 next cycle, then 0000; head=tail=3.
- Enqueue 16 instructions over cycles with dequeue of 4 per cycle starting from tail=14 → out lanes cross entries 14,15,0,1 in program order.
- count=10, flush=1 with in_en=1111 and stall=1 in the same cycle → out_en=0 and in_ready=0 that cycle; next cycle count=0 and the dropped group is not stored.
- Assert rst low mid-fill (count=7) → out_en=0 and in_ready=1 immediately; full_cycles=0.

Source files
------------

// File: rtl/inst_buffer.sv
// inst_buffer: circular instruction queue between fetch/predecode and decode.
// Accepts up to FETCH_WIDTH instructions per cycle and presents up to
// FETCH_WIDTH instructions per cycle in program order. Flush empties it.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   in_en                 per-lane valid from fetch (contiguous from lane 0)
//   in_inst/iam/ipf/fsq   per-lane payload from fetch
//   in_ready              group accepted this cycle (registered count only)
//   stall                 backend not consuming
//   flush                 backend redirect / commit walk, highest priority
//   out_en                per-lane valid to decode
//   out_inst/iam/ipf/fsq  head entries, lane i = head+i
//   full_cycles           saturating count of cycles fetch was refused
module inst_buffer #(
  parameter int FETCH_WIDTH = 4,
  parameter int DEPTH       = 16,
  parameter int INST_W      = 32,
  parameter int FSQ_INFO_W  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [FETCH_WIDTH-1:0]           in_en,
  input  logic [FETCH_WIDTH*INST_W-1:0]    in_inst,
  input  logic [FETCH_WIDTH-1:0]           in_iam,
  input  logic [FETCH_WIDTH-1:0]           in_ipf,
  input  logic [FETCH_WIDTH*FSQ_INFO_W-1:0] in_fsq_info,
  output logic                             in_ready,
  input  logic                             stall,
  input  logic                             flush,
  output logic [FETCH_WIDTH-1:0]           out_en,
  output logic [FETCH_WIDTH*INST_W-1:0]    out_inst,
  output logic [FETCH_WIDTH-1:0]           out_iam,
  output logic [FETCH_WIDTH-1:0]           out_ipf,
  output logic [FETCH_WIDTH*FSQ_INFO_W-1:0] out_fsq_info,
  output logic [31:0]                      full_cycles
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] SPACE_MAX = CNT_W'(DEPTH - FETCH_WIDTH);
  localparam logic [CNT_W-1:0] FW_C      = CNT_W'(FETCH_WIDTH);

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic [INST_W-1:0]     mem_inst [DEPTH];
  logic                  mem_iam  [DEPTH];
  logic                  mem_ipf  [DEPTH];
  logic [FSQ_INFO_W-1:0] mem_fsq  [DEPTH];

  logic             enq;
  logic             deq;
  logic [CNT_W-1:0] enq_cnt;
  logic [CNT_W-1:0] deq_cnt;

  // Readiness deliberately ignores this cycle's dequeue to keep the
  // fetch-side handshake off the decode/backpressure timing path.
  assign in_ready = ~flush & (count <= SPACE_MAX);
  assign enq      = in_ready & (|in_en);
  assign deq      = ~stall & ~flush;

  always_comb begin
    enq_cnt = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (in_en[i]) enq_cnt = enq_cnt + CNT_W'(1);
    end
    if (!enq) enq_cnt = '0;
    deq_cnt = '0;
    if (deq) deq_cnt = (count < FW_C) ? count : FW_C;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + deq_cnt[PTR_W-1:0];
      tail  <= tail + enq_cnt[PTR_W-1:0];
      count <= count + enq_cnt - deq_cnt;
    end
  end

  // Payload storage has no reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
        if (in_en[i]) begin
          mem_inst[tail + PTR_W'(i)] <= in_inst[i*INST_W +: INST_W];
          mem_iam[tail + PTR_W'(i)]  <= in_iam[i];
          mem_ipf[tail + PTR_W'(i)]  <= in_ipf[i];
          mem_fsq[tail + PTR_W'(i)]  <= in_fsq_info[i*FSQ_INFO_W +: FSQ_INFO_W];
        end
      end
    end
  end

  always_comb begin
    out_en       = '0;
    out_inst     = '0;
    out_iam      = '0;
    out_ipf      = '0;
    out_fsq_info = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      out_en[i]                                 = ~flush & (CNT_W'(i) < count);
      out_inst[i*INST_W +: INST_W]              = mem_inst[head + PTR_W'(i)];
      out_iam[i]                                = mem_iam[head + PTR_W'(i)];
      out_ipf[i]                                = mem_ipf[head + PTR_W'(i)];
      out_fsq_info[i*FSQ_INFO_W +: FSQ_INFO_W]  = mem_fsq[head + PTR_W'(i)];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_cycles <= '0;
    end else if (~in_ready & (|in_en) & ~flush & (full_cycles != '1)) begin
      full_cycles <= full_cycles + 32'd1;
    end
  end

endmodule
